// File: rtl/ps2_keyboard_frontend.sv
// rtl/ps2_keyboard_frontend.sv - PS/2 keyboard receiver with 7-segment readout and 1 Hz divider
// Bytes arrive on device-clocked frames; every valid byte is strobed and shown on HEX1:HEX0.
module ps2_keyboard_frontend #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int DIV_HALF = CLK_HZ / 2,
   parameter int TIMEOUT  = 10_000
) (
   input  logic       CLOCK_50,
   input  logic       RESETN,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT,
   output logic [7:0] ps2_key_data,
   output logic       ps2_key_pressed,
   output logic [7:0] last_data_received,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic       clk_1hz
);

   localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           r_state;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_parity;
   logic [TO_W-1:0]  r_to_cnt;
   logic [7:0]       r_key_data;
   logic [7:0]       r_last_data;
   logic             r_pressed;
   logic             r_clk_s1, r_clk_s2, r_clk_prev;
   logic             r_dat_s1, r_dat_s2;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_clk_1hz;
   logic             w_fall;
   logic             w_timeout;

   // Receive-only: the keyboard owns both lines.
   assign PS2_CLK = 1'bz;
   assign PS2_DAT = 1'bz;

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= PS2_CLK;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= PS2_DAT;
         r_dat_s2   <= r_dat_s1;
      end
   end

   assign w_fall    = r_clk_prev & ~r_clk_s2;
   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'd0;
         r_parity    <= 1'b0;
         r_to_cnt    <= '0;
         r_key_data  <= 8'd0;
         r_last_data <= 8'd0;
         r_pressed   <= 1'b0;
      end else begin
         r_pressed <= 1'b0;
         if (r_state == S_IDLE || w_fall)
            r_to_cnt <= '0;
         else
            r_to_cnt <= r_to_cnt + 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_fall && !r_dat_s2) begin
                  r_state   <= S_DATA;
                  r_bit_cnt <= 3'd0;
               end
            end
            S_DATA: begin
               if (w_fall) begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7)
                     r_state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (w_fall) begin
                  r_parity <= r_dat_s2;
                  r_state  <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_fall) begin
                  r_state <= S_IDLE;
                  // Odd parity over data+parity, and a high stop bit.
                  if (r_dat_s2 && (^{r_shift, r_parity})) begin
                     r_key_data  <= r_shift;
                     r_last_data <= r_shift;
                     r_pressed   <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (r_state != S_IDLE && !w_fall && w_timeout)
            r_state <= S_IDLE;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         r_div_cnt <= '0;
         r_clk_1hz <= 1'b0;
      end else if (r_div_cnt == DIV_W'(DIV_HALF - 1)) begin
         r_div_cnt <= '0;
         r_clk_1hz <= ~r_clk_1hz;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   assign ps2_key_data       = r_key_data;
   assign ps2_key_pressed    = r_pressed;
   assign last_data_received = r_last_data;
   assign HEX0               = hex7(r_last_data[3:0]);
   assign HEX1               = hex7(r_last_data[7:4]);
   assign clk_1hz            = r_clk_1hz;

endmodule

// File: tb/tb_ps2_keyboard_frontend.sv
// tb/tb_ps2_keyboard_frontend.sv - directed self-checking bench for ps2_keyboard_frontend
module tb_ps2_keyboard_frontend;

   localparam int TIMEOUT = 200;
   localparam int H       = 10;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk_drv;
   logic       ps2_dat_drv;
   wire        ps2_clk_w;
   wire        ps2_dat_w;
   logic [7:0] key_data;
   logic       key_pressed;
   logic [7:0] last_data;
   logic [6:0] hex0, hex1;
   logic       clk_1hz;

   int         checks   = 0;
   int         failures = 0;
   int         n_strobes = 0;
   logic [7:0] strobe_log [0:63];
   logic [6:0] seg_tab [0:15];

   assign ps2_clk_w = ps2_clk_drv;
   assign ps2_dat_w = ps2_dat_drv;

   ps2_keyboard_frontend #(
      .CLK_HZ(50_000_000), .DIV_HALF(4), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLOCK_50(clk), .RESETN(rst_n), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
      .ps2_key_data(key_data), .ps2_key_pressed(key_pressed),
      .last_data_received(last_data), .HEX0(hex0), .HEX1(hex1), .clk_1hz(clk_1hz)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (key_pressed === 1'b1) begin
         if (n_strobes < 64) strobe_log[n_strobes] = key_data;
         n_strobes = n_strobes + 1;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
      logic par;
      par = ~^b ^ bad_par;
      return {stop, par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_dat_drv = bits[i];
         wait_cycles(H);
         ps2_clk_drv = 1'b0;
         wait_cycles(H);
         ps2_clk_drv = 1'b1;
      end
      ps2_dat_drv = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(frame(b, 1'b0, 1'b1), 11);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_cycles(3);
      checks++;
      if (key_data !== 8'h00 || last_data !== 8'h00 || key_pressed !== 1'b0 || clk_1hz !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: data=%h last=%h pressed=%b clk1hz=%b, required 00 00 0 0",
                  key_data, last_data, key_pressed, clk_1hz);
      end
      checks++;
      if (hex0 !== 7'h40 || hex1 !== 7'h40) begin
         failures++;
         $display("FAIL reset_hex: hex1=%h hex0=%h, required 40 40", hex1, hex0);
      end
   endtask

   task automatic test_divider;
      logic exp;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         exp = ((k / 4) % 2) == 1;
         checks++;
         if (clk_1hz !== exp) begin
            failures++;
            $display("FAIL divider_edge%0d: clk_1hz=%b, required %b", k, clk_1hz, exp);
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (clk_1hz !== 1'b0) begin
         failures++;
         $display("FAIL divider_async_reset: clk_1hz=%b, required 0", clk_1hz);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         exp = (k == 4);
         checks++;
         if (clk_1hz !== exp) begin
            failures++;
            $display("FAIL divider_restart%0d: clk_1hz=%b, required %b", k, clk_1hz, exp);
         end
      end
      wait_cycles(2);
   endtask

   task automatic test_valid_frame;
      int s0;
      s0 = n_strobes;
      send_byte(8'h1C);
      wait_cycles(5);
      checks++;
      if (n_strobes - s0 !== 1 || key_data !== 8'h1C || last_data !== 8'h1C) begin
         failures++;
         $display("FAIL valid_1c: strobes=%0d data=%h last=%h, required 1 1c 1c",
                  n_strobes - s0, key_data, last_data);
      end
      checks++;
      if (hex0 !== 7'h46 || hex1 !== 7'h79) begin
         failures++;
         $display("FAIL hex_1c: hex1=%h hex0=%h, required 79 46", hex1, hex0);
      end
   endtask

   task automatic test_bad_frames;
      int s0;
      s0 = n_strobes;
      send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
      wait_cycles(5);
      send_bits(frame(8'h3A, 1'b1, 1'b1), 11);
      wait_cycles(5);
      send_bits(frame(8'h55, 1'b0, 1'b0), 11);
      wait_cycles(5);
      checks++;
      if (n_strobes - s0 !== 0 || key_data !== 8'h1C || last_data !== 8'h1C) begin
         failures++;
         $display("FAIL bad_frames: strobes=%0d data=%h last=%h, required 0 1c 1c",
                  n_strobes - s0, key_data, last_data);
      end
   endtask

   task automatic test_back_to_back;
      int s0;
      s0 = n_strobes;
      send_byte(8'hF0);
      send_byte(8'h1C);
      wait_cycles(5);
      checks++;
      if (n_strobes - s0 !== 2) begin
         failures++;
         $display("FAIL b2b_count: strobes=%0d, required 2", n_strobes - s0);
      end else begin
         checks++;
         if (strobe_log[s0] !== 8'hF0 || strobe_log[s0+1] !== 8'h1C || last_data !== 8'h1C) begin
            failures++;
            $display("FAIL b2b_data: first=%h second=%h last=%h, required f0 1c 1c",
                     strobe_log[s0], strobe_log[s0+1], last_data);
         end
      end
   endtask

   task automatic test_timeout;
      int s0;
      s0 = n_strobes;
      send_bits(frame(8'hA5, 1'b0, 1'b1), 5);
      wait_cycles(TIMEOUT + 5);
      send_byte(8'h29);
      wait_cycles(5);
      checks++;
      if (n_strobes - s0 !== 1 || key_data !== 8'h29) begin
         failures++;
         $display("FAIL timeout_recover: strobes=%0d data=%h, required 1 29", n_strobes - s0, key_data);
      end
   endtask

   task automatic test_reset_mid_frame;
      int s0;
      send_bits(frame(8'h77, 1'b0, 1'b1), 6);
      @(negedge clk);
      rst_n = 1'b0;
      wait_cycles(2);
      checks++;
      if (key_data !== 8'h00 || last_data !== 8'h00) begin
         failures++;
         $display("FAIL midframe_reset: data=%h last=%h, required 00 00", key_data, last_data);
      end
      rst_n = 1'b1;
      wait_cycles(3);
      s0 = n_strobes;
      send_byte(8'h5A);
      wait_cycles(5);
      checks++;
      if (n_strobes - s0 !== 1 || key_data !== 8'h5A) begin
         failures++;
         $display("FAIL midframe_next: strobes=%0d data=%h, required 1 5a", n_strobes - s0, key_data);
      end
   endtask

   task automatic test_hex_sweep;
      logic [7:0] b;
      for (int n = 0; n < 16; n++) begin
         b = 8'(n * 8'h11);
         send_byte(b);
         wait_cycles(5);
         checks++;
         if (last_data !== b || hex0 !== seg_tab[n] || hex1 !== seg_tab[n]) begin
            failures++;
            $display("FAIL hex_sweep_%h: last=%h hex1=%h hex0=%h, required %h %h %h",
                     b, last_data, hex1, hex0, b, seg_tab[n], seg_tab[n]);
         end
      end
   endtask

   initial begin
      seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
      seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
      seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
      seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
      ps2_clk_drv = 1'b1;
      ps2_dat_drv = 1'b1;
      rst_n       = 1'b0;

      test_reset;
      test_divider;
      test_valid_frame;
      test_bad_frames;
      test_back_to_back;
      test_timeout;
      test_reset_mid_frame;
      test_hex_sweep;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
